pc_sequencer: RTL and testbench

//  Program-counter sequencer for the fetch stage: owns the D-bit PC, steps it by +1 per cycle,

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_sequencer_lut.sv | 30 +++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int DEFAULT_D  = 12;
  localparam int DEFAULT_CW = 16;
  localparam int LUT_IDX_W  = 3;

endpackage

// File: rtl/pc_sequencer_lut.sv
// Branch-offset LUT: maps a 3-bit index to a D-bit two's-complement PC offset.
module PC_LUT
  import pc_seq_pkg::*;
#(
  parameter int D = DEFAULT_D
) (
  input  logic [LUT_IDX_W-1:0] how_high,
  output logic [D-1:0]         offset
);

  int offset_val;

  // Select the signed offset, then truncate to the PC width so adds wrap mod 2**D.
  always_comb begin
    offset_val = 0;
    case (how_high)
      3'd0: offset_val = 2;
      3'd1: offset_val = -19;
      3'd2: offset_val = 22;
      3'd3: offset_val = -26;
      3'd4: offset_val = 130;
      3'd5: offset_val = -132;
      3'd6: offset_val = 162;
      3'd7: offset_val = -168;
      default: offset_val = 0;
    endcase
    offset = D'(offset_val);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with stall/branch/halt handling and
// saturating run-cycle and taken-branch counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int           D        = DEFAULT_D,
  parameter logic [D-1:0] START_PC = '0,
  parameter int           CW       = DEFAULT_CW
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic [LUT_IDX_W-1:0] how_high,
  input  logic                 halt_req,
  output logic [D-1:0]         pc,
  output logic                 fetch_en,
  output logic                 done,
  output logic [CW-1:0]        cycle_cnt,
  output logic [CW-1:0]        branch_cnt
);

  seq_state_t   state;
  logic [D-1:0] offset;
  logic [D-1:0] pc_next;
  logic         branch_taken;

  PC_LUT #(.D(D)) u_lut (
    .how_high (how_high),
    .offset   (offset)
  );

  // A stall outranks a branch, so a branch only counts when the PC is allowed to move.
  assign branch_taken = branch_en && !stall;

  // Next PC while running: hold on stall, relative jump on branch, otherwise step by one.
  always_comb begin
    pc_next = pc;
    if (stall)
      pc_next = pc;
    else if (branch_en)
      pc_next = pc + offset;
    else
      pc_next = pc + 1'b1;
  end

  // Status flags come straight from the state register, so no input reaches them combinationally.
  assign fetch_en = (state == RUN);
  assign done     = (state == HALT);

  // Sequencer state, PC and the two saturating counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= START_PC;
      cycle_cnt  <= '0;
      branch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          pc <= START_PC;
          if (start) begin
            state      <= RUN;
            cycle_cnt  <= '0;
            branch_cnt <= '0;
          end
        end
        RUN: begin
          if (cycle_cnt != '1)
            cycle_cnt <= cycle_cnt + 1'b1;
          if (halt_req) begin
            state <= HALT;
          end else begin
            pc <= pc_next;
            if (branch_taken && (branch_cnt != '1))
              branch_cnt <= branch_cnt + 1'b1;
          end
        end
        HALT: begin
          if (start) begin
            state      <= RUN;
            pc         <= START_PC;
            cycle_cnt  <= '0;
            branch_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          pc    <= START_PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (D=12, START_PC=0, CW=8 so saturation is reachable).
module tb_pc_sequencer;

  localparam int D  = 12;
  localparam int CW = 8;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic          stall;
  logic          branch_en;
  logic [2:0]    how_high;
  logic          halt_req;
  logic [D-1:0]  pc;
  logic          fetch_en;
  logic          done;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] branch_cnt;

  int error_count = 0;
  int check_count = 0;

  pc_sequencer #(.D(D), .START_PC('0), .CW(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .stall      (stall),
    .branch_en  (branch_en),
    .how_high   (how_high),
    .halt_req   (halt_req),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .done       (done),
    .cycle_cnt  (cycle_cnt),
    .branch_cnt (branch_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic applyStimulus(input logic st, input logic sl, input logic be,
                               input logic [2:0] hh, input logic hr);
    start     = st;
    stall     = sl;
    branch_en = be;
    how_high  = hh;
    halt_req  = hr;
  endtask

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int exp_pc, input int exp_fetch,
                          input int exp_done, input int exp_cyc, input int exp_br);
    checkOutput({tag, ".pc"},         32'(pc),         32'(exp_pc));
    checkOutput({tag, ".fetch_en"},   32'(fetch_en),   32'(exp_fetch));
    checkOutput({tag, ".done"},       32'(done),       32'(exp_done));
    checkOutput({tag, ".cycle_cnt"},  32'(cycle_cnt),  32'(exp_cyc));
    checkOutput({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(exp_br));
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(2);
    checkAll("reset", 0, 0, 0, 0, 0);

    // IDLE ignores branch/stall/halt requests.
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    tick(1);
    checkAll("idle_hold", 0, 0, 0, 0, 0);

    // Start pulse: first RUN cycle keeps pc at START_PC, then +1 per cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkAll("start_edge", 0, 1, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkAll("run1", 1, 1, 0, 1, 0);
    tick(1);
    checkOutput("run2.pc", 32'(pc), 32'd2);
    tick(1);
    checkOutput("run3.pc", 32'(pc), 32'd3);
    tick(17);
    checkAll("run20", 20, 1, 0, 20, 0);

    // Branch offsets: 20-19=1, then walk through every LUT entry including both wrap directions.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick(1);
    checkAll("br_m19", 1, 1, 0, 21, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(4);
    checkOutput("step_to5.pc", 32'(pc), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    tick(1);
    checkAll("br_m168_wrap", 3933, 1, 0, 26, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    tick(1);
    checkOutput("br_p162.pc", 32'(pc), 32'd4095);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkOutput("inc_wrap.pc", 32'(pc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    tick(1);
    checkAll("br_p130", 130, 1, 0, 29, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    tick(1);
    checkOutput("br_m132.pc", 32'(pc), 32'd4094);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick(1);
    checkOutput("br_p2_wrap.pc", 32'(pc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    tick(1);
    checkOutput("br_p22.pc", 32'(pc), 32'd22);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    tick(1);
    checkAll("br_m26", 4092, 1, 0, 33, 8);

    // Stall beats branch: pc held, cycles still counted, no branch counted.
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    tick(3);
    checkAll("stall3", 4092, 1, 0, 36, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkOutput("post_stall.pc", 32'(pc), 32'd4093);

    // Halt beats branch; halting cycle is counted.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    tick(1);
    checkAll("halt", 4093, 0, 1, 38, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
    tick(2);
    checkAll("halt_frozen", 4093, 0, 1, 38, 8);

    // Restart from HALT clears counters and reloads START_PC.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkAll("restart", 0, 1, 0, 0, 0);

    // Start held while RUN has no effect.
    tick(1);
    checkAll("start_in_run", 1, 1, 0, 1, 0);

    // Counter saturation at 2**CW-1 = 255.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick(254);
    checkAll("pre_sat", 509, 1, 0, 255, 254);
    tick(1);
    checkAll("at_sat", 511, 1, 0, 255, 255);
    tick(45);
    checkAll("held_sat", 601, 1, 0, 255, 255);

    // Reset mid-RUN with start/branch high wins.
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    tick(1);
    checkAll("reset_run", 0, 0, 0, 0, 0);
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkAll("after_reset", 0, 0, 0, 0, 0);

    // Reset mid-HALT.
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick(1);
    checkAll("halt2", 2, 0, 1, 3, 0);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    checkAll("reset_halt", 0, 0, 0, 0, 0);
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
